// File: rtl/sip_in_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : sip_in_fifo
// | Description : 10-lane, 8-entry single-clock input FIFO with nibble packing
// |               and empty/full/almost flags.
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
module sip_in_fifo #(
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter     ARRAY_MODE         = "ARRAY_MODE_4_X_8",
  parameter     SYNCHRONOUS_MODE   = "FALSE"
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_wren,
  input  logic       i_rden,
  input  logic [3:0] i_d0,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d4,
  input  logic [7:0] i_d5,
  input  logic [7:0] i_d6,
  input  logic [3:0] i_d7,
  input  logic [3:0] i_d8,
  input  logic [3:0] i_d9,
  output logic [7:0] o_q0,
  output logic [7:0] o_q1,
  output logic [7:0] o_q2,
  output logic [7:0] o_q3,
  output logic [7:0] o_q4,
  output logic [7:0] o_q5,
  output logic [7:0] o_q6,
  output logic [7:0] o_q7,
  output logic [7:0] o_q8,
  output logic [7:0] o_q9,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_almostempty,
  output logic       o_almostfull
);

  localparam int c_lanes = 10;
  localparam int c_depth = 8;
  localparam bit c_mode_4x8 = (ARRAY_MODE == "ARRAY_MODE_4_X_8");
  localparam bit c_mode_4x4 = (ARRAY_MODE == "ARRAY_MODE_4_X_4");

  generate
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2) begin : g_bad_almost_empty
      $fatal(1, "sip_in_fifo: ALMOST_EMPTY_VALUE must be 1..2");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_almost_full
      $fatal(1, "sip_in_fifo: ALMOST_FULL_VALUE must be 1..2");
    end
    if (!c_mode_4x8 && !c_mode_4x4) begin : g_bad_array_mode
      $fatal(1, "sip_in_fifo: ARRAY_MODE must be ARRAY_MODE_4_X_8 or ARRAY_MODE_4_X_4");
    end
    if (SYNCHRONOUS_MODE != "FALSE") begin : g_bad_sync_mode
      $fatal(1, "sip_in_fifo: SYNCHRONOUS_MODE must be FALSE");
    end
  endgenerate

  logic [7:0] w_din   [c_lanes];
  logic [7:0] w_entry [c_lanes];
  logic [3:0] r_stage [c_lanes];
  logic [7:0] r_mem   [c_depth][c_lanes];
  logic [7:0] r_q     [c_lanes];

  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic       r_phase;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_commit;

  // 4-bit lanes are zero-extended; lanes 5 and 6 carry a full byte.
  assign w_din[0] = {4'h0, i_d0};
  assign w_din[1] = {4'h0, i_d1};
  assign w_din[2] = {4'h0, i_d2};
  assign w_din[3] = {4'h0, i_d3};
  assign w_din[4] = {4'h0, i_d4};
  assign w_din[5] = i_d5;
  assign w_din[6] = i_d6;
  assign w_din[7] = {4'h0, i_d7};
  assign w_din[8] = {4'h0, i_d8};
  assign w_din[9] = {4'h0, i_d9};

  always_comb begin
    for (int l = 0; l < c_lanes; l++) begin
      w_entry[l] = c_mode_4x8 ? {w_din[l][3:0], r_stage[l]} : w_din[l];
    end
  end

  assign w_wr_acc = i_wren & ~o_full;
  assign w_rd_acc = i_rden & ~o_empty;
  assign w_commit = w_wr_acc & (~c_mode_4x8 | r_phase);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_commit, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 4'd1;
      2'b01:   w_count_nxt = r_count - 4'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_count  <= 4'd0;
      r_phase  <= 1'b0;
      for (int l = 0; l < c_lanes; l++) begin
        r_stage[l] <= 4'h0;
        r_q[l]     <= 8'h00;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_wr_acc) begin
        r_phase <= c_mode_4x8 ? ~r_phase : 1'b0;
        if (!r_phase) begin
          for (int l = 0; l < c_lanes; l++) begin
            r_stage[l] <= w_din[l][3:0];
          end
        end
      end
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + 3'd1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
        for (int l = 0; l < c_lanes; l++) begin
          r_q[l] <= r_mem[r_rd_ptr][l];
        end
      end
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int l = 0; l < c_lanes; l++) begin
        r_mem[r_wr_ptr][l] <= w_entry[l];
      end
    end
  end

  assign o_q0 = r_q[0];
  assign o_q1 = r_q[1];
  assign o_q2 = r_q[2];
  assign o_q3 = r_q[3];
  assign o_q4 = r_q[4];
  assign o_q5 = r_q[5];
  assign o_q6 = r_q[6];
  assign o_q7 = r_q[7];
  assign o_q8 = r_q[8];
  assign o_q9 = r_q[9];

  assign o_empty       = (r_count == 4'd0);
  assign o_full        = (r_count == 4'd8);
  assign o_almostempty = (r_count <= 4'(ALMOST_EMPTY_VALUE));
  assign o_almostfull  = ((4'd8 - r_count) <= 4'(ALMOST_FULL_VALUE));

endmodule
`default_nettype wire

// File: tb/tb_sip_in_fifo.sv
`default_nettype none
// Directed bench: dut_a runs 4_X_4 with ALMOST_FULL_VALUE=2, dut_b runs 4_X_8 defaults.
module tb_sip_in_fifo;

  logic       clk;
  logic       nrst;
  logic       a_wren, a_rden, b_wren, b_rden;
  logic [7:0] a_d [10];
  logic [7:0] b_d [10];
  logic [7:0] a_q [10];
  logic [7:0] b_q [10];
  logic       a_empty, a_full, a_aempty, a_afull;
  logic       b_empty, b_full, b_aempty, b_afull;

  int n_pass  = 0;
  int n_total = 0;

  sip_in_fifo #(
    .ALMOST_EMPTY_VALUE (1),
    .ALMOST_FULL_VALUE  (2),
    .ARRAY_MODE         ("ARRAY_MODE_4_X_4"),
    .SYNCHRONOUS_MODE   ("FALSE")
  ) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_wren(a_wren), .i_rden(a_rden),
    .i_d0(a_d[0][3:0]), .i_d1(a_d[1][3:0]), .i_d2(a_d[2][3:0]), .i_d3(a_d[3][3:0]),
    .i_d4(a_d[4][3:0]), .i_d5(a_d[5]), .i_d6(a_d[6]), .i_d7(a_d[7][3:0]),
    .i_d8(a_d[8][3:0]), .i_d9(a_d[9][3:0]),
    .o_q0(a_q[0]), .o_q1(a_q[1]), .o_q2(a_q[2]), .o_q3(a_q[3]), .o_q4(a_q[4]),
    .o_q5(a_q[5]), .o_q6(a_q[6]), .o_q7(a_q[7]), .o_q8(a_q[8]), .o_q9(a_q[9]),
    .o_empty(a_empty), .o_full(a_full), .o_almostempty(a_aempty), .o_almostfull(a_afull)
  );

  sip_in_fifo #(
    .ALMOST_EMPTY_VALUE (1),
    .ALMOST_FULL_VALUE  (1),
    .ARRAY_MODE         ("ARRAY_MODE_4_X_8"),
    .SYNCHRONOUS_MODE   ("FALSE")
  ) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_wren(b_wren), .i_rden(b_rden),
    .i_d0(b_d[0][3:0]), .i_d1(b_d[1][3:0]), .i_d2(b_d[2][3:0]), .i_d3(b_d[3][3:0]),
    .i_d4(b_d[4][3:0]), .i_d5(b_d[5]), .i_d6(b_d[6]), .i_d7(b_d[7][3:0]),
    .i_d8(b_d[8][3:0]), .i_d9(b_d[9][3:0]),
    .o_q0(b_q[0]), .o_q1(b_q[1]), .o_q2(b_q[2]), .o_q3(b_q[3]), .o_q4(b_q[4]),
    .o_q5(b_q[5]), .o_q6(b_q[6]), .o_q7(b_q[7]), .o_q8(b_q[8]), .o_q9(b_q[9]),
    .o_empty(b_empty), .o_full(b_full), .o_almostempty(b_aempty), .o_almostfull(b_afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wren = 1'b0; a_rden = 1'b0; b_wren = 1'b0; b_rden = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_d[i] = 8'h00;
      b_d[i] = 8'h00;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;

    // Reset state
    check("rst_a_empty", a_empty, 1);
    check("rst_a_aempty", a_aempty, 1);
    check("rst_a_full", a_full, 0);
    check("rst_a_afull", a_afull, 0);
    for (int l = 0; l < 10; l++) check($sformatf("rst_a_q%0d", l), a_q[l], 0);
    check("rst_b_empty", b_empty, 1);
    check("rst_b_full", b_full, 0);
    check("rst_b_q0", b_q[0], 0);

    // 4_X_4 single write/read
    a_wren = 1; a_d[0] = 8'h0A; a_d[5] = 8'h5C; a_d[9] = 8'h03;
    step();
    idle();
    check("x4_wr_empty", a_empty, 0);
    check("x4_wr_aempty", a_aempty, 1);
    a_rden = 1;
    step();
    idle();
    check("x4_rd_q0", a_q[0], 8'h0A);
    check("x4_rd_q5", a_q[5], 8'h5C);
    check("x4_rd_q9", a_q[9], 8'h03);
    check("x4_rd_empty", a_empty, 1);

    // Fill to 8 with ALMOST_FULL_VALUE=2
    for (int k = 0; k < 8; k++) begin
      a_wren = 1; a_d[0] = 8'(k); a_d[5] = 8'h80 | 8'(k);
      step();
      if (k == 4) check("fill_afull_c5", a_afull, 0);
      if (k == 5) check("fill_afull_c6", a_afull, 1);
      if (k == 6) check("fill_full_c7", a_full, 0);
      if (k == 7) check("fill_full_c8", a_full, 1);
    end
    a_d[0] = 8'h0F; a_d[5] = 8'hFF;
    step();
    check("fill_9th_full", a_full, 1);

    // Read+write at full: only the read happens
    a_wren = 1; a_rden = 1; a_d[0] = 8'h0E; a_d[5] = 8'hEE;
    step();
    idle();
    check("full_rw_q0", a_q[0], 8'h00);
    check("full_rw_q5", a_q[5], 8'h80);
    check("full_rw_full", a_full, 0);
    check("full_rw_afull", a_afull, 1);
    for (int k = 1; k < 8; k++) begin
      a_rden = 1;
      step();
      check($sformatf("drain_q0_%0d", k), a_q[0], 8'(k));
      check($sformatf("drain_q5_%0d", k), a_q[5], 8'h80 | 8'(k));
    end
    idle();
    check("drain_empty", a_empty, 1);

    // Read while empty with a simultaneous write
    a_rden = 1; a_wren = 1; a_d[0] = 8'h09; a_d[5] = 8'h99;
    step();
    idle();
    check("emp_rw_q0", a_q[0], 8'h07);
    check("emp_rw_q5", a_q[5], 8'h87);
    check("emp_rw_empty", a_empty, 0);
    check("emp_rw_aempty", a_aempty, 1);
    a_rden = 1;
    step();
    idle();
    check("emp_rw_rd_q0", a_q[0], 8'h09);
    check("emp_rw_rd_q5", a_q[5], 8'h99);
    check("emp_rw_rd_empty", a_empty, 1);

    // Pointer wrap: keep two entries in flight over 20 read/write pairs
    for (int k = 0; k < 2; k++) begin
      a_wren = 1; a_d[0] = 8'(k) & 8'h0F; a_d[5] = 8'h40 + 8'(k);
      step();
    end
    check("wrap_prime_aempty", a_aempty, 0);
    for (int j = 0; j < 20; j++) begin
      a_wren = 1; a_rden = 1;
      a_d[0] = 8'(j + 2) & 8'h0F; a_d[5] = 8'h40 + 8'(j + 2);
      step();
      check($sformatf("wrap_q0_%0d", j), a_q[0], 8'(j) & 8'h0F);
      check($sformatf("wrap_q5_%0d", j), a_q[5], 8'h40 + 8'(j));
      check($sformatf("wrap_aempty_%0d", j), a_aempty, 0);
    end
    idle();
    a_rden = 1;
    step();
    check("wrap_tail1_q5", a_q[5], 8'h54);
    check("wrap_tail1_aempty", a_aempty, 1);
    step();
    check("wrap_tail2_q5", a_q[5], 8'h55);
    check("wrap_tail2_empty", a_empty, 1);
    idle();

    // 4_X_8 nibble pairing
    b_wren = 1; b_d[0] = 8'h03; b_d[5] = 8'hF1;
    step();
    idle();
    check("x8_ph0_empty", b_empty, 1);
    b_wren = 1; b_d[0] = 8'h07; b_d[5] = 8'hE2;
    step();
    idle();
    check("x8_ph1_empty", b_empty, 0);
    check("x8_ph1_aempty", b_aempty, 1);
    b_rden = 1;
    step();
    idle();
    check("x8_rd_q0", b_q[0], 8'h73);
    check("x8_rd_q5", b_q[5], 8'h21);
    check("x8_rd_empty", b_empty, 1);

    // Reset with a pending half-entry discards the staged nibble
    b_wren = 1; b_d[0] = 8'h0C;
    step();
    idle();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    check("midrst_b_empty", b_empty, 1);
    check("midrst_b_q0", b_q[0], 0);
    b_wren = 1; b_d[0] = 8'h05;
    step();
    check("midrst_ph0_empty", b_empty, 1);
    b_d[0] = 8'h06;
    step();
    idle();
    check("midrst_ph1_empty", b_empty, 0);
    b_rden = 1;
    step();
    idle();
    check("midrst_rd_q0", b_q[0], 8'h65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
